// File: rtl/pc_flag_unit.sv
// Program counter, Z/V/N flag register and halt state, sitting between the opcode decoder and instruction memory.
// Define PC_BR_COUNT_EN to add a saturating taken-branch counter (br_count).
module pc_flag_unit #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          Branch,
    input  logic                halt,
    input  logic                zEn,
    input  logic                vEn,
    input  logic                nEn,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_n,
    input  logic [2:0]          cond,
    input  logic [8:0]          offset,
    input  logic [PC_WIDTH-1:0] rs_data,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus2,
    output logic [2:0]          flags,
    output logic                taken,
    output logic                halted
`ifdef PC_BR_COUNT_EN
    ,
    output logic [15:0]         br_count
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]          flags_q, flags_d;
    logic                flag_z, flag_v, flag_n;
    logic                cond_true;
    logic                is_branch;
    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] rel_target;

    assign flag_z = flags_q[2];
    assign flag_v = flags_q[1];
    assign flag_n = flags_q[0];

    // Branch conditions always look at the registered flags, so a flag write
    // in the same instruction only affects the following branch.
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            3'd0:    cond_true = !flag_z;
            3'd1:    cond_true = flag_z;
            3'd2:    cond_true = !flag_z && !flag_n;
            3'd3:    cond_true = flag_n;
            3'd4:    cond_true = flag_z || (!flag_z && !flag_n);
            3'd5:    cond_true = flag_n || flag_z;
            3'd6:    cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    assign is_branch  = (Branch == 2'b01) || (Branch == 2'b10);
    assign halted     = (state_q == ST_HALTED);
    assign taken      = is_branch && cond_true && !halted && !halt;
    assign pc_plus2   = pc_q + PC_WIDTH'(2);
    assign off_ext    = {{(PC_WIDTH-9){offset[8]}}, offset} << 1;
    assign rel_target = pc_plus2 + off_ext;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        if (state_q == ST_RUN) begin
            if (halt) begin
                // HLT keeps its own address in pc and drops any flag write.
                state_d = ST_HALTED;
            end else begin
                if (taken && (Branch == 2'b01)) begin
                    pc_d = rel_target;
                end else if (taken && (Branch == 2'b10)) begin
                    pc_d = rs_data;
                end else begin
                    pc_d = pc_plus2;
                end
                if (zEn) flags_d[2] = alu_z;
                if (vEn) flags_d[1] = alu_v;
                if (nEn) flags_d[0] = alu_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign pc    = pc_q;
    assign flags = flags_q;

`ifdef PC_BR_COUNT_EN
    logic [15:0] br_count_q;

    // taken is already forced low while halted, which freezes the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q <= 16'h0000;
        end else if (taken && (br_count_q != 16'hFFFF)) begin
            br_count_q <= br_count_q + 16'h0001;
        end
    end

    assign br_count = br_count_q;
`endif

endmodule

// File: tb/tb_pc_flag_unit.sv
// Randomised and directed bench for pc_flag_unit against a behavioural model.
module tb_pc_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  Branch;
    logic        halt, zEn, vEn, nEn, alu_z, alu_v, alu_n;
    logic [2:0]  cond;
    logic [8:0]  offset;
    logic [15:0] rs_data;
    logic [15:0] pc, pc_plus2;
    logic [2:0]  flags;
    logic        taken, halted;
`ifdef PC_BR_COUNT_EN
    logic [15:0] br_count;
`endif

    pc_flag_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .Branch(Branch), .halt(halt),
        .zEn(zEn), .vEn(vEn), .nEn(nEn),
        .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .cond(cond), .offset(offset), .rs_data(rs_data),
        .pc(pc), .pc_plus2(pc_plus2), .flags(flags),
        .taken(taken), .halted(halted)
`ifdef PC_BR_COUNT_EN
        , .br_count(br_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state
    int m_pc;
    bit mz, mv, mn, mh;
    int m_cnt;
    bit m_taken;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_cond(input logic [2:0] c);
        case (c)
            3'd0: return !mz;
            3'd1: return mz;
            3'd2: return !mz && !mn;
            3'd3: return mn;
            3'd4: return mz || !mn;
            3'd5: return mn || mz;
            3'd6: return mv;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; mz = 0; mv = 0; mn = 0; mh = 0; m_cnt = 0;
    endtask

    task automatic set_in(input logic [1:0] br, input logic h, input logic [2:0] en,
                          input logic [2:0] alu, input logic [2:0] c,
                          input logic [8:0] off, input logic [15:0] rs);
        Branch = br; halt = h;
        {zEn, vEn, nEn} = en;
        {alu_z, alu_v, alu_n} = alu;
        cond = c; offset = off; rs_data = rs;
    endtask

    // One instruction: check combinational outputs mid-cycle, clock, check state.
    task automatic cycle();
        int soff;
        @(negedge clk);
        m_taken = (Branch == 2'b01 || Branch == 2'b10) && m_cond(cond) && !mh && !halt;
        chk("taken", taken, m_taken);
        chk("pc_plus2", pc_plus2, (m_pc + 2) % 65536);
        if (!mh) begin
            if (halt) begin
                mh = 1;
            end else begin
                soff = offset[8] ? int'(offset) - 512 : int'(offset);
                if (m_taken && Branch == 2'b01)      m_pc = (m_pc + 2 + 2 * soff + 65536) % 65536;
                else if (m_taken && Branch == 2'b10) m_pc = int'(rs_data);
                else                                 m_pc = (m_pc + 2) % 65536;
                if (zEn) mz = alu_z;
                if (vEn) mv = alu_v;
                if (nEn) mn = alu_n;
                if (m_taken && m_cnt < 65535) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("flags", flags, {mz, mv, mn});
        chk("halted", halted, mh);
`ifdef PC_BR_COUNT_EN
        chk("br_count", br_count, m_cnt);
`endif
    endtask

    // Reset asserted away from any clock edge; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_pc", pc, 16'h0000);
        chk("async_rst_halted", halted, 1'b0);
        chk("async_rst_flags", flags, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] exp_pat;
    int         halt_age;

    initial begin
        rst = 1'b1;
        set_in(2'b00, 0, 3'b000, 3'b000, 3'd0, 9'd0, 16'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_flags", flags, 3'b000);
        chk("reset_halted", halted, 1'b0);
        rst = 1'b0;

        // Sequential stepping from reset
        for (int i = 0; i < 3; i++) cycle();
        chk("seq_pc", pc, 16'h0006);

        // Same-cycle flag write uses old Z
        set_in(2'b10, 0, 3'b000, 3'b000, 3'd7, 9'd0, 16'h0010); cycle();
        set_in(2'b01, 0, 3'b100, 3'b100, 3'd1, 9'h004, 16'h0);  cycle();
        chk("eq_old_flag_pc", pc, 16'h0012);
        set_in(2'b01, 0, 3'b000, 3'b000, 3'd1, 9'h004, 16'h0);  cycle();
        chk("eq_new_flag_pc", pc, 16'h001C);

        // Negative offset, register target, wrap
        set_in(2'b10, 0, 3'b000, 3'b000, 3'd7, 9'd0, 16'h0020); cycle();
        set_in(2'b01, 0, 3'b000, 3'b000, 3'd7, 9'h1FF, 16'h0);  cycle();
        chk("neg_off_pc", pc, 16'h0020);
        set_in(2'b10, 0, 3'b000, 3'b000, 3'd7, 9'd0, 16'hFFFE); cycle();
        chk("br_pc", pc, 16'hFFFE);
        set_in(2'b00, 0, 3'b000, 3'b000, 3'd0, 9'd0, 16'h0);    cycle();
        chk("wrap_pc", pc, 16'h0000);

        // Condition table with Z=0 V=1 N=0
        set_in(2'b00, 0, 3'b111, 3'b010, 3'd0, 9'd0, 16'h0);    cycle();
        exp_pat = 8'hD5;
        for (int c = 0; c < 8; c++) begin
            set_in(2'b01, 0, 3'b000, 3'b000, 3'(c), 9'd0, 16'h0);
            cycle();
            chk("cond_pattern", m_taken, exp_pat[c]);
        end

        // Halt wins over branch; halted state freezes everything
        set_in(2'b10, 0, 3'b000, 3'b000, 3'd7, 9'd0, 16'h0040); cycle();
        set_in(2'b01, 1, 3'b000, 3'b000, 3'd7, 9'h010, 16'h0);  cycle();
        chk("halt_pc", pc, 16'h0040);
        chk("halt_halted", halted, 1'b1);
        set_in(2'b10, 0, 3'b111, 3'b111, 3'd7, 9'd0, 16'h1234);
        cycle(); cycle();
        chk("frozen_pc", pc, 16'h0040);
        do_reset();

`ifdef PC_BR_COUNT_EN
        for (int i = 0; i < 7; i++) begin
            if (i == 2 || i == 5) set_in(2'b00, 0, 3'b000, 3'b000, 3'd7, 9'd0, 16'h0);
            else                  set_in(2'b01, 0, 3'b000, 3'b000, 3'd7, 9'h002, 16'h0);
            cycle();
        end
        chk("count_five", br_count, 16'd5);
        do_reset();
        set_in(2'b10, 0, 3'b000, 3'b000, 3'd7, 9'd0, 16'h0);
        repeat (65535) @(posedge clk);
        #1;
        m_pc = 0; m_cnt = 65535;
        chk("count_full", br_count, 16'hFFFF);
        cycle();
        chk("count_sat", br_count, 16'hFFFF);
        do_reset();
`endif

        // Randomised run
        halt_age = 0;
        for (int i = 0; i < 400; i++) begin
            if (mh && halt_age >= 3) begin
                do_reset();
                halt_age = 0;
            end
            set_in(2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0),
                   3'($urandom), 3'($urandom), 3'($urandom), 9'($urandom),
                   ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom));
            cycle();
            if (mh) halt_age++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
